// File: rtl/paddle_key_controller.sv
// paddle_key_controller: turns raw board keys into a per-frame paddle position with serve and pause controls
//   clk      game clock (divided pixel clock)
//   reset    asynchronous assert, synchronous release, active-low
//   keys     raw active-high keys: [0]=left [1]=right [2]=serve [3]=pause
//   vsync    vertical sync, active-high
//   hpaddle  paddle position, clamped to [PADDLE_MIN,PADDLE_MAX]
//   serve    one-clock serve pulse (suppressed while paused)
//   paused   pause state level
//   frame    one-clock pulse on the synced vsync rising edge
//   Define PADDLE_WRAP_EN to wrap around the range instead of saturating.
module paddle_key_controller #(
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_MIN   = 0,
    parameter int PADDLE_MAX   = 240,
    parameter int DEBOUNCE_CYC = 16,
    parameter int SPEED_MAX    = 4,
    parameter int ACCEL_FRAMES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          keys,
    input  logic                vsync,
    output logic [PADDLE_W-1:0] hpaddle,
    output logic                serve,
    output logic                paused,
    output logic                frame
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = $clog2(SPEED_MAX + 1);
    localparam int HW = $clog2(ACCEL_FRAMES + 1);
    localparam int XW = PADDLE_W + 2;
    localparam logic signed [XW-1:0] LO = XW'(PADDLE_MIN);
    localparam logic signed [XW-1:0] HI = XW'(PADDLE_MAX);
    localparam logic [PADDLE_W-1:0] MID = PADDLE_W'((PADDLE_MIN + PADDLE_MAX) / 2);
    typedef enum logic [1:0] {IDLE, MOVE_L, MOVE_R, PAUSED} state_t;
    state_t state;
    logic [3:0] k_s1, k_s2, deb, deb_q;
    logic [CW-1:0] cnt [4];
    logic v_s1, v_s2, v_q;
    logic [SW-1:0] speed, eff_spd, spd_up;
    logic [HW-1:0] hold, hold_inc;
    logic frame_c, srv_e, pse_e, lo, ro, go, same, acc;
    logic signed [XW-1:0] pos_x, step_x, sum, nxt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_s1  <= '0;
            k_s2  <= '0;
            v_s1  <= 1'b0;
            v_s2  <= 1'b0;
            v_q   <= 1'b0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            k_s1  <= keys;
            k_s2  <= k_s1;
            v_s1  <= vsync;
            v_s2  <= v_s1;
            v_q   <= v_s2;
            deb_q <= deb;
            // a key flips only after DEBOUNCE_CYC consecutive differing samples
            for (int i = 0; i < 4; i++)
                if (k_s2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= k_s2[i];
                end else cnt[i] <= cnt[i] + CW'(1);
        end
    end
    assign frame_c = v_s2 & ~v_q;
    assign srv_e   = deb[2] & ~deb_q[2];
    assign pse_e   = deb[3] & ~deb_q[3];
    assign lo      = deb[0] & ~deb[1];
    assign ro      = deb[1] & ~deb[0];
    assign go      = lo | ro;
    // continuing in the same direction keeps the built-up speed; a new direction restarts at 1
    assign same     = (lo && state == MOVE_L) || (ro && state == MOVE_R);
    assign eff_spd  = same ? speed : SW'(1);
    assign hold_inc = (same ? hold : '0) + HW'(1);
    assign acc      = hold_inc == HW'(ACCEL_FRAMES);
    assign spd_up   = eff_spd == SW'(SPEED_MAX) ? eff_spd : eff_spd + SW'(1);
    assign pos_x    = {2'b00, hpaddle};
    assign step_x   = XW'(eff_spd);
    assign sum      = lo ? pos_x - step_x : pos_x + step_x;
`ifdef PADDLE_WRAP_EN
    // overshoot past one end continues from the other end
    assign nxt = sum > HI ? sum - HI - XW'(1) + LO :
                 sum < LO ? sum - LO + XW'(1) + HI : sum;
`else
    assign nxt = sum > HI ? HI : sum < LO ? LO : sum;
`endif
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            hpaddle <= MID;
            speed   <= SW'(1);
            hold    <= '0;
            serve   <= 1'b0;
            paused  <= 1'b0;
            frame   <= 1'b0;
        end else begin
            frame <= frame_c;
            // a pause edge in the same clock swallows the serve edge
            serve <= srv_e & ~pse_e & ~paused;
            if (pse_e) begin
                paused <= ~paused;
                state  <= state == PAUSED ? IDLE : PAUSED;
                if (state == PAUSED) begin
                    speed <= SW'(1);
                    hold  <= '0;
                end
            end else if (frame_c && state != PAUSED) begin
                state   <= go ? (lo ? MOVE_L : MOVE_R) : IDLE;
                hpaddle <= go ? PADDLE_W'(nxt) : hpaddle;
                speed   <= go ? (acc ? spd_up : eff_spd) : SW'(1);
                hold    <= go ? (acc ? '0 : hold_inc) : '0;
            end
        end
    end
endmodule

// File: tb/tb_paddle_key_controller.sv
// tb_paddle_key_controller: randomized and directed checks of paddle_key_controller against a behavioural model
module tb_paddle_key_controller;
    localparam int W = 8, MIN = 0, MAX = 240, D = 16, SMAX = 4, ACC = 8;
    logic clk = 1'b0, reset = 1'b1, vsync = 1'b0;
    logic [3:0] keys = 4'b0000;
    logic [W-1:0] hpaddle;
    logic serve, paused, frame;
    int n_checks = 0, n_fail = 0;
    int m_pos, m_spd, m_hold, m_dir;
    bit m_paused;

    paddle_key_controller #(.PADDLE_W(W), .PADDLE_MIN(MIN), .PADDLE_MAX(MAX),
        .DEBOUNCE_CYC(D), .SPEED_MAX(SMAX), .ACCEL_FRAMES(ACC)) dut (
        .clk(clk), .reset(reset), .keys(keys), .vsync(vsync),
        .hpaddle(hpaddle), .serve(serve), .paused(paused), .frame(frame));

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_keys(input logic [3:0] k);
        keys = k;
        tick(D + 4);
    endtask

    task automatic pulse_vsync(output int nf);
        nf = 0;
        vsync = 1'b1;
        repeat (5) begin tick(1); if (frame === 1'b1) nf++; end
        vsync = 1'b0;
        repeat (3) begin tick(1); if (frame === 1'b1) nf++; end
    endtask

    function automatic int limit(input int p);
`ifdef PADDLE_WRAP_EN
        if (p > MAX) return MIN + (p - MAX - 1);
        if (p < MIN) return MAX - (MIN - 1 - p);
        return p;
`else
        return p > MAX ? MAX : (p < MIN ? MIN : p);
`endif
    endfunction

    task automatic model_reset();
        m_pos = (MIN + MAX) / 2; m_spd = 1; m_hold = 0; m_dir = 0; m_paused = 0;
    endtask

    task automatic model_frame(input bit l, input bit r);
        int d;
        if (m_paused) return;
        if (l == r) begin
            m_dir = 0; m_spd = 1; m_hold = 0;
            return;
        end
        d = l ? -1 : 1;
        if (d != m_dir) begin m_spd = 1; m_hold = 0; end
        m_dir = d;
        m_pos = limit(m_pos + d * m_spd);
        m_hold++;
        if (m_hold == ACC) begin
            m_hold = 0;
            if (m_spd < SMAX) m_spd++;
        end
    endtask

    task automatic model_pause();
        m_paused = !m_paused;
        if (!m_paused) begin m_dir = 0; m_spd = 1; m_hold = 0; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        model_reset();
    endtask

    task automatic test_reset();
        tick(1);
        keys = 4'b0011;
        reset = 1'b0;
        tick(3);
        n_checks++; if (hpaddle !== 8'd120) begin n_fail++; $display("FAIL reset_hpaddle got %0d want 120", hpaddle); end
        n_checks++; if (serve !== 1'b0) begin n_fail++; $display("FAIL reset_serve got %b want 0", serve); end
        n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused got %b want 0", paused); end
        n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b want 0", frame); end
        reset = 1'b1;
        keys = 4'b0000;
        tick(D + 10);
        model_reset();
        n_checks++; if (hpaddle !== 8'd120) begin n_fail++; $display("FAIL idle_no_vsync got %0d want 120", hpaddle); end
    endtask

    task automatic test_bounce();
        int nf;
        repeat (5) begin keys[1] = ~keys[1]; tick(1); end
        tick(D + 4);
        for (int i = 1; i <= 3; i++) begin
            pulse_vsync(nf);
            model_frame(0, 1);
            n_checks++; if (nf != 1) begin n_fail++; $display("FAIL frame_pulse got %0d pulses want 1", nf); end
            n_checks++; if (hpaddle !== W'(120 + i)) begin n_fail++; $display("FAIL bounce_step%0d got %0d want %0d", i, hpaddle, 120 + i); end
        end
        set_keys(4'b0000);
        pulse_vsync(nf);
        model_frame(0, 0);
    endtask

    task automatic test_accel();
        int nf;
        do_reset();
        set_keys(4'b0010);
        for (int i = 1; i <= 20; i++) begin
            pulse_vsync(nf);
            model_frame(0, 1);
            n_checks++; if (hpaddle !== W'(m_pos)) begin n_fail++; $display("FAIL accel_frame%0d got %0d want %0d", i, hpaddle, m_pos); end
        end
        n_checks++; if (hpaddle !== 8'd156) begin n_fail++; $display("FAIL accel_total got %0d want 156", hpaddle); end
        set_keys(4'b0011);
        pulse_vsync(nf);
        model_frame(1, 1);
        n_checks++; if (hpaddle !== 8'd156) begin n_fail++; $display("FAIL both_keys got %0d want 156", hpaddle); end
    endtask

    task automatic test_saturate();
        int nf;
        set_keys(4'b0010);
        for (int i = 0; i < 36; i++) begin
            pulse_vsync(nf);
            model_frame(0, 1);
            n_checks++; if (hpaddle !== W'(m_pos)) begin n_fail++; $display("FAIL right_edge_frame%0d got %0d want %0d", i, hpaddle, m_pos); end
        end
`ifndef PADDLE_WRAP_EN
        n_checks++; if (hpaddle !== W'(MAX)) begin n_fail++; $display("FAIL saturate_max got %0d want %0d", hpaddle, MAX); end
`endif
        set_keys(4'b0001);
        for (int i = 0; i < 80; i++) begin
            pulse_vsync(nf);
            model_frame(1, 0);
            n_checks++; if (hpaddle !== W'(m_pos)) begin n_fail++; $display("FAIL left_edge_frame%0d got %0d want %0d", i, hpaddle, m_pos); end
        end
`ifndef PADDLE_WRAP_EN
        n_checks++; if (hpaddle !== W'(MIN)) begin n_fail++; $display("FAIL saturate_min got %0d want %0d", hpaddle, MIN); end
`endif
        set_keys(4'b0000);
        pulse_vsync(nf);
        model_frame(0, 0);
    endtask

    task automatic test_async_reset();
        int nf;
        do_reset();
        set_keys(4'b0001);
        repeat (3) pulse_vsync(nf);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (hpaddle !== 8'd120) begin n_fail++; $display("FAIL async_reset got %0d want 120", hpaddle); end
        keys = 4'b0000;
        tick(D + 4);
        reset = 1'b1;
        tick(2);
        model_reset();
    endtask

    task automatic test_pause();
        int nf, ns;
        logic [W-1:0] p0;
        set_keys(4'b1000);
        model_pause();
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_on got %b want 1", paused); end
        p0 = hpaddle;
        set_keys(4'b0001);
        for (int i = 0; i < 3; i++) begin
            pulse_vsync(nf);
            model_frame(1, 0);
            n_checks++; if (hpaddle !== p0 || hpaddle !== W'(m_pos)) begin n_fail++; $display("FAIL pause_freeze got %0d want %0d", hpaddle, p0); end
        end
        ns = 0;
        keys = 4'b0101;
        repeat (D + 8) begin tick(1); if (serve === 1'b1) ns++; end
        n_checks++; if (ns != 0) begin n_fail++; $display("FAIL serve_while_paused got %0d pulses want 0", ns); end
        set_keys(4'b0000);
        set_keys(4'b1000);
        model_pause();
        n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL pause_off got %b want 0", paused); end
        set_keys(4'b0000);
    endtask

    task automatic test_serve();
        int ns, at;
        ns = 0; at = -1;
        keys = 4'b0100;
        for (int k = 1; k <= D + 8; k++) begin
            tick(1);
            if (serve === 1'b1) begin ns++; at = k; end
        end
        n_checks++; if (ns != 1) begin n_fail++; $display("FAIL serve_count got %0d want 1", ns); end
        n_checks++; if (at != D + 3) begin n_fail++; $display("FAIL serve_latency got %0d want %0d", at, D + 3); end
        ns = 0;
        keys = 4'b0000;
        repeat (D + 8) begin tick(1); if (serve === 1'b1) ns++; end
        n_checks++; if (ns != 0) begin n_fail++; $display("FAIL serve_release got %0d pulses want 0", ns); end
    endtask

    task automatic test_pause_wins();
        int ns;
        ns = 0;
        keys = 4'b1100;
        repeat (D + 8) begin tick(1); if (serve === 1'b1) ns++; end
        model_pause();
        n_checks++; if (ns != 0) begin n_fail++; $display("FAIL pause_wins_serve got %0d pulses want 0", ns); end
        n_checks++; if (paused !== 1'b1) begin n_fail++; $display("FAIL pause_wins_paused got %b want 1", paused); end
        set_keys(4'b0000);
        set_keys(4'b1000);
        model_pause();
        set_keys(4'b0000);
        n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL pause_wins_resume got %b want 0", paused); end
    endtask

    task automatic test_random();
        int nf;
        logic [1:0] dir;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_keys(keys | 4'b1000);
                model_pause();
                set_keys(keys & 4'b0111);
                n_checks++; if (paused !== m_paused) begin n_fail++; $display("FAIL rand_pause%0d got %b want %b", it, paused, m_paused); end
            end else begin
                dir = 2'($urandom_range(0, 3));
                set_keys({2'b00, dir});
                repeat ($urandom_range(1, 4)) begin
                    pulse_vsync(nf);
                    model_frame(dir[0], dir[1]);
                    n_checks++; if (hpaddle !== W'(m_pos)) begin n_fail++; $display("FAIL rand_move%0d got %0d want %0d", it, hpaddle, m_pos); end
                end
            end
        end
        set_keys(4'b0000);
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_accel();
        test_saturate();
        test_async_reset();
        test_pause();
        test_serve();
        test_pause_wins();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
